// File: rtl/store_lane_buf_pkg.sv
// store_pkg: size encodings, the buffered store entry, and lane replication.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam int unsigned ENTRY_W = 66;

  // One buffered store: word address, lane-replicated data, byte enables.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } entry_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
  } lane_t;

  // Little-endian lane placement. Reserved size falls through to word.
  function automatic lane_t lane_pack(input size_e sz, input logic [1:0] a,
                                      input logic [31:0] d);
    lane_t r;
    case (sz)
      SZ_BYTE: begin
        r.wdata = {4{d[7:0]}};
        r.be    = 4'b0001 << a;
      end
      SZ_HALF: begin
        r.wdata = {2{d[15:0]}};
        r.be    = a[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        r.wdata = d;
        r.be    = 4'b1111;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_lane_buf_fifo.sv
// sb_fifo: DEPTH x 66-bit circular buffer; full/empty resolved from a count.
module sb_fifo
  import store_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  entry_t                   i_din,
  input  logic                     i_pop,
  output entry_t                   o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  entry_t        r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/store_lane_buf.sv
// store_lane_buf: narrows sb/sh/sw into lane-replicated words with byte
// enables, buffers them, and drains to data memory over req/ack.
// Optional: STORE_MISALIGN_EXC_EN rejects misaligned/reserved stores.
module store_lane_buf
  import store_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_size,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        misalign,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  lane_t       w_lane;
  entry_t      w_din;
  entry_t      w_head;
  logic [AW:0] w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_bad;
  logic        w_push;
  logic        w_pop;
  logic        r_misalign;

  // Build the entry for the incoming store.
  always_comb begin
    w_lane      = lane_pack(size_e'(in_size), in_addr[1:0], in_data);
    w_din       = '0;
    w_din.addr  = in_addr[31:2];
    w_din.wdata = w_lane.wdata;
    w_din.be    = w_lane.be;
  end

  // Rejection check for illegal size/alignment combinations.
  always_comb begin
`ifdef STORE_MISALIGN_EXC_EN
    w_bad = (in_size == SZ_RSVD) ||
            ((in_size == SZ_HALF) && in_addr[0]) ||
            ((in_size == SZ_WORD) && (in_addr[1:0] != 2'b00));
`else
    w_bad = 1'b0;
`endif
  end

  assign in_ready = !w_full;
  assign w_accept = in_valid && !w_full;
  assign w_push   = w_accept && !w_bad;
  assign mem_req  = (w_count != '0);
  assign w_pop    = mem_req && mem_ack;
  assign empty    = w_empty;

  // Head is masked to zero while empty so stale storage never shows.
  assign mem_addr  = w_empty ? '0 : {w_head.addr, 2'b00};
  assign mem_wdata = w_empty ? '0 : w_head.wdata;
  assign mem_be    = w_empty ? '0 : w_head.be;
  assign misalign  = r_misalign;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // One-cycle pulse after a rejected store is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_accept && w_bad;
  end

endmodule

// File: doc/store_lane_buf.md
# store_lane_buf

Store-side narrowing and buffering unit for the MIPS datapath. It is the write-direction counterpart of the immediate/load widening logic. It accepts sb/sh/sw requests from the MEM stage and converts the 32-bit register operand into a lane-replicated word with byte enables. It queues the results in a small FIFO and drains them to data memory over a req/ack handshake, so the pipeline does not stall on memory write latency.

## Interface
Parameters:
- DEPTH, 2: store buffer entries; power of two, 2..8.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  store request present
- in_ready  out  1  buffer can accept this cycle
- in_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- in_addr  in  32  byte address
- in_data  in  32  register value; only low 8/16 bits are significant for byte/halfword stores
- mem_req  out  1  write request to data memory
- mem_ack  in  1  memory accepted current request
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables; bit i enables bits [8i+7:8i]
- misalign  out  1  one-cycle pulse for a rejected store
- empty  out  1  no stores pending; used for load ordering and sync

## Operation
- Little-endian lanes. Byte lane is in_addr[1:0].
  - Byte: wdata = {4{d[7:0]}}, be = 4'b0001 << a[1:0].
  - Half: wdata = {2{d[15:0]}}, be = a[1] ? 4'b1100 : 4'b0011.
  - Word: wdata = d, be = 4'b1111.
- A store is accepted when in_valid && in_ready. in_ready = !full and does not depend on mem_ack (no same-cycle full bypass).
- Each entry holds {addr[31:2], wdata, be}, 66 bits. Entries drain in strict FIFO order.
- Drain side:
  - mem_req = !empty. mem_addr/mem_wdata/mem_be present the head entry.
  - An entry is popped on mem_req && mem_ack.
  - Outputs are held stable while mem_req && !mem_ack.
  - mem_ack while mem_req is low is ignored.
- Push and pop in the same cycle leave the count unchanged and are legal at any level below full. At full, only the pop occurs.
- Pointer wrap: read and write pointers are log2(DEPTH) bits wrapping modulo DEPTH. Full/empty are resolved with a separate count register (0..DEPTH).
- Reset (async, any time): count = 0, pointers = 0, misalign = 0. Consequences: mem_req = 0, empty = 1, in_ready = 1. Pending stores are discarded. mem_addr/wdata/be reset to 0.

## Timing
- Push latency: a store accepted at edge N makes mem_req high during cycle N+1 when the buffer was empty. mem_req is driven from registered state only, with no combinational path from in_*.
- Throughput: one push and one pop per cycle. With mem_ack held high, a stream of stores sustains one store per cycle after the first.
- empty deasserts in cycle N+1 after a push at edge N. It asserts in the cycle after the pop of the last entry.
- misalign is registered and pulses high for exactly the cycle after the rejected acceptance edge.

## Configuration
- STORE_MISALIGN_EXC_EN defined:
  - Stores are rejected in these cases: halfword with a[0]=1, word with a[1:0]!=0, size 11.
  - A rejected store is consumed (in_ready unaffected, handshake completes) but not enqueued, and misalign pulses.
  - The FIFO state is unchanged.
- STORE_MISALIGN_EXC_EN undefined:
  - Address bits are ignored where illegal: halfword uses a[1] only, word ignores a[1:0], size 11 is treated as word.
  - misalign is tied to 0.

## Structure
- Package store_pkg holds:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD.
  - The 66-bit entry struct.
  - A pure function that computes {wdata, be} from size, a[1:0] and data.
- Sub-module sb_fifo is a parameterised DEPTH x 66 circular buffer with push/pop/count/full/empty. The top level holds the lane logic, the misalign check and the misalign register.

## Test plan
- Reset: assert rst mid-drain with 2 entries held → same cycle mem_req=0, empty=1, in_ready=1. After release, no stale write appears.
- Lanes: sb addr 0x1003 data 0xAABBCCDD → mem_addr 0x1000, wdata 0xDDDDDDDD, be 1000. sh addr 0x2002 data 0x12345678 → wdata 0x56785678, be 1100.
- Backpressure: DEPTH=2, mem_ack=0, push 3 stores → in_ready=0 after 2 pushes, head outputs stable for 10 cycles. One ack → 1 pop, in_ready=1 the next cycle.
- Simultaneous: count=1 with push and ack in the same cycle → count stays 1, order preserved across pointer wrap over 20 stores with random ack.
- Misalign (macro on): sw addr 0x3001 → consumed, misalign=1 for one cycle, empty stays 1. Macro off: same store → be 1111, mem_addr 0x3000, misalign=0.
- Streaming: 8 sw with mem_ack tied 1 → 8 consecutive mem_req cycles starting one cycle after the first push, addresses in order.
